// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding, weight clamp and
// lowest-set-bit-to-index helper.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // A programmed weight of zero behaves as a weight of one.
  function automatic int unsigned clamp_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned lsb_index(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (vec[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// Combinational fixed-priority arbiter: lowest-index request wins, one-hot out.
module fixed_prio_arb #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + NUM_PORTS'(1));

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered grants held for up to the
// grantee's weight in acknowledged transfers, with back-to-back hand-off.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int WEIGHT_W  = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  input  logic                          ack_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [IDX_W-1:0]              gnt_idx_o,
  output logic                          gnt_vld_o
);

  arb_state_e           state;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     last_idx;
  logic [WEIGHT_W-1:0]  credit;

  logic [IDX_W-1:0]     ptr;
  logic [NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0] masked_req;
  logic [NUM_PORTS-1:0] masked_gnt;
  logic [NUM_PORTS-1:0] raw_gnt;
  logic [NUM_PORTS-1:0] win_oh;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [WEIGHT_W-1:0]  win_weight;
  logic [WEIGHT_W-1:0]  load_credit;
  logic                 release_gnt;

  // Arbitration is only consumed in IDLE or on release; on release the
  // pointer has just become cur_idx, so use it directly in GRANT.
  assign ptr = (state == ARB_GRANT) ? cur_idx : last_idx;

  always_comb begin
    mask = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      mask[p] = (p > 32'(ptr));
    end
  end

  assign masked_req = req_i & mask;

  fixed_prio_arb #(.NUM_PORTS(NUM_PORTS)) u_masked_arb (
    .req (masked_req),
    .gnt (masked_gnt)
  );

  fixed_prio_arb #(.NUM_PORTS(NUM_PORTS)) u_raw_arb (
    .req (req_i),
    .gnt (raw_gnt)
  );

  assign win_oh  = (|masked_req) ? masked_gnt : raw_gnt;
  assign win_vld = |req_i;
  assign win_idx = IDX_W'(lsb_index(32'(win_oh)));

  always_comb begin
    int unsigned base;
    base        = 32'(win_idx) * WEIGHT_W;
    win_weight  = weight_i[base +: WEIGHT_W];
    load_credit = WEIGHT_W'(clamp_weight(32'(win_weight)));
  end

  assign release_gnt = !req_i[cur_idx] || (ack_i && credit == WEIGHT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      cur_idx   <= '0;
      last_idx  <= IDX_W'(NUM_PORTS - 1);
      credit    <= '0;
      gnt_o     <= '0;
      gnt_vld_o <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_vld) begin
            state     <= ARB_GRANT;
            cur_idx   <= win_idx;
            credit    <= load_credit;
            gnt_o     <= win_oh;
            gnt_vld_o <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_gnt) begin
            last_idx <= cur_idx;
            if (win_vld) begin
              cur_idx   <= win_idx;
              credit    <= load_credit;
              gnt_o     <= win_oh;
              gnt_vld_o <= 1'b1;
            end else begin
              state     <= ARB_IDLE;
              credit    <= '0;
              gnt_o     <= '0;
              gnt_vld_o <= 1'b0;
            end
          end else if (ack_i) begin
            credit <= credit - WEIGHT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_idx_o = cur_idx;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (4 ports, 4-bit weights).
module tb_wrr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [15:0] weight_i;
  logic        ack_i;
  logic [3:0]  gnt_o;
  logic [1:0]  gnt_idx_o;
  logic        gnt_vld_o;

  int tests;
  int fails;

  wrr_arbiter #(.NUM_PORTS(4), .WEIGHT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .weight_i  (weight_i),
    .ack_i     (ack_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .gnt_vld_o (gnt_vld_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    reset    = 1'b1;
    req_i    = '0;
    ack_i    = 1'b0;
    weight_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (gnt_o !== 4'b0000 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b vld=%b idx=%0d, required 0000/0/0", gnt_o, gnt_vld_o, gnt_idx_o);
    end
    weight_i = {4'd3, 4'd3, 4'd3, 4'd3};
    req_i    = 4'b0110;
    @(negedge clk);
    tests++;
    if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1 || gnt_vld_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_grant: gnt=%b idx=%0d vld=%b, required 0010/1/1", gnt_o, gnt_idx_o, gnt_vld_o);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (gnt_o !== 4'b0000 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: gnt=%b vld=%b idx=%0d, required 0000/0/0", gnt_o, gnt_vld_o, gnt_idx_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1) begin
      fails++;
      $display("FAIL reset_restart: gnt=%b idx=%0d, required 0010/1", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_equal_weights();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    req_i    = 4'b1111;
    ack_i    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (gnt_idx_o !== exp_seq[i] || gnt_vld_o !== 1'b1 || gnt_o !== (4'b0001 << exp_seq[i])) begin
        fails++;
        $display("FAIL equal_w[%0d]: idx=%0d vld=%b gnt=%b, required idx=%0d vld=1", i, gnt_idx_o, gnt_vld_o, gnt_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_weighted();
    logic [1:0] exp_seq [8];
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    do_reset();
    weight_i = {4'd0, 4'd2, 4'd1, 4'd3};
    req_i    = 4'b1111;
    ack_i    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (gnt_idx_o !== exp_seq[i] || gnt_vld_o !== 1'b1) begin
        fails++;
        $display("FAIL weighted[%0d]: idx=%0d vld=%b, required idx=%0d vld=1", i, gnt_idx_o, gnt_vld_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_withdrawal();
    do_reset();
    weight_i = {4'd1, 4'd5, 4'd1, 4'd4};
    req_i    = 4'b0100;
    @(negedge clk);
    tests++;
    if (gnt_idx_o !== 2'd2 || gnt_o !== 4'b0100) begin
      fails++;
      $display("FAIL withdraw_grant2: idx=%0d gnt=%b, required 2/0100", gnt_idx_o, gnt_o);
    end
    req_i = 4'b0101;
    ack_i = 1'b1;
    @(negedge clk);
    tests++;
    if (gnt_idx_o !== 2'd2) begin
      fails++;
      $display("FAIL withdraw_after_ack: idx=%0d, required 2", gnt_idx_o);
    end
    req_i = 4'b0001;
    ack_i = 1'b0;
    @(negedge clk);
    tests++;
    if (gnt_idx_o !== 2'd0 || gnt_o !== 4'b0001 || gnt_vld_o !== 1'b1) begin
      fails++;
      $display("FAIL withdraw_wrap: idx=%0d gnt=%b vld=%b, required 0/0001/1", gnt_idx_o, gnt_o, gnt_vld_o);
    end
    // Port 0 credit is 4: three acks keep it, the fourth hands over to port 1.
    req_i = 4'b0011;
    ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (gnt_idx_o !== 2'd0) begin
        fails++;
        $display("FAIL withdraw_reload[%0d]: idx=%0d, required 0", i, gnt_idx_o);
      end
    end
    @(negedge clk);
    tests++;
    if (gnt_idx_o !== 2'd1 || gnt_o !== 4'b0010) begin
      fails++;
      $display("FAIL withdraw_handoff: idx=%0d gnt=%b, required 1/0010", gnt_idx_o, gnt_o);
    end
  endtask

  task automatic test_lone_requester();
    do_reset();
    weight_i = {4'd2, 4'd0, 4'd0, 4'd0};
    req_i    = 4'b1000;
    ack_i    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (gnt_o !== 4'b1000 || gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd3) begin
        fails++;
        $display("FAIL lone[%0d]: gnt=%b vld=%b idx=%0d, required 1000/1/3", i, gnt_o, gnt_vld_o, gnt_idx_o);
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd2, 4'd1};
    req_i    = 4'b0010;
    @(negedge clk);
    req_i = 4'b0110;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt_o !== 4'b0010 || gnt_vld_o !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d cycles lost grant, required 0 (last gnt=%b)", bad, gnt_o);
    end
    ack_i = 1'b1;
    @(negedge clk);
    tests++;
    if (gnt_idx_o !== 2'd1) begin
      fails++;
      $display("FAIL stall_ack1: idx=%0d, required 1", gnt_idx_o);
    end
    @(negedge clk);
    tests++;
    if (gnt_idx_o !== 2'd2 || gnt_o !== 4'b0100) begin
      fails++;
      $display("FAIL stall_ack2: idx=%0d gnt=%b, required 2/0100", gnt_idx_o, gnt_o);
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    req_i    = 4'b0001;
    ack_i    = 1'b1;
    @(negedge clk);
    req_i = 4'b0000;
    @(negedge clk);
    tests++;
    if (gnt_o !== 4'b0000 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      fails++;
      $display("FAIL idle_return: gnt=%b vld=%b idx=%0d, required 0000/0/0", gnt_o, gnt_vld_o, gnt_idx_o);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    req_i    = '0;
    ack_i    = 1'b0;
    weight_i = '0;
    test_reset();
    test_equal_weights();
    test_weighted();
    test_withdrawal();
    test_lone_requester();
    test_stall();
    test_idle_return();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Parametrised weighted round-robin arbiter with registered, handshake-held grants. It serves NUM_PORTS requesters sharing one downstream resource. A winner keeps the grant for up to its programmed weight of acknowledged transfers, or until it drops its request, and then priority rotates past it. It sits between request sources and a shared bus or port and replaces the plain combinational round-robin arbiter where fairness by weight and stable grants are required.

## Interface
- NUM_PORTS, 4, number of requesters; legal range 2..32.
- WEIGHT_W, 4, width of each per-port weight and of the credit counter.
- IDX_W, $clog2(NUM_PORTS), width of gnt_idx_o; derived, never overridden.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_i  in  NUM_PORTS  per-port request level; held high until served or withdrawn.
- weight_i  in  NUM_PORTS*WEIGHT_W  per-port weight, packed with port p at bits [p*WEIGHT_W +: WEIGHT_W]; a value of 0 is treated as 1.
- ack_i  in  1  downstream consumed one transfer from the current grantee this cycle.
- gnt_o  out  NUM_PORTS  registered grant; one-hot or all-zero.
- gnt_idx_o  out  IDX_W  binary index of the current grantee; holds its last value while idle.
- gnt_vld_o  out  1  high when gnt_o is non-zero.

## Operation
- State: a two-state FSM, IDLE and GRANT. It holds:
  - cur_idx, the current grantee;
  - last_idx, the rotation pointer;
  - credit, a WEIGHT_W-bit counter.
- Arbitration function:
  - Build a mask of ports strictly above last_idx.
  - If req_i & mask is non-zero, pick its lowest set bit.
  - Otherwise pick the lowest set bit of req_i (wrap-around).
- Release condition, evaluated only in GRANT:
  - req_i[cur_idx] is 0 (withdrawn), or
  - ack_i=1 while credit==1 (weight exhausted).
- IDLE:
  - If req_i is non-zero, arbitrate, load credit = max(weight_i[winner],1), and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT without release:
  - On ack_i, credit decrements by 1.
  - Without ack_i, all state holds.
- GRANT with release:
  - Set last_idx = cur_idx.
  - Arbitrate in the same cycle using the updated pointer, excluding no ports.
  - If a winner exists, stay in GRANT with the new winner and a reloaded credit. There is no idle bubble.
  - If there is no winner, go to IDLE.
- A lone requester is re-granted to itself on exhaustion through the wrap path, with credit reloaded and no bubble.
- weight_i is sampled only when credit loads. Changes during a grant take effect at the next load.
- ack_i is ignored in IDLE. ack_i in the same cycle that req_i[cur_idx] drops counts as a release; no extra decrement is visible.

## Timing
- Reset values:
  - gnt_o=0, gnt_vld_o=0, gnt_idx_o=0;
  - last_idx=NUM_PORTS-1, so port 0 has the highest priority first;
  - credit=0, state=IDLE.
- Latency: a request sampled at edge t produces a grant visible after edge t, i.e. one cycle.
- Hand-off: a release at edge t moves gnt_o to the new winner after edge t. Grants are back-to-back.
- gnt_o, gnt_idx_o and gnt_vld_o come straight from flops, with no combinational path from inputs.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock. On reset release, arbitration restarts from port 0 priority.
- Credit never underflows. Decrement happens only when credit is 2 or more; credit==1 with ack releases.

## Structure
- Package arb_pkg holds:
  - the FSM state enum (ARB_IDLE, ARB_GRANT);
  - a function for the weight-0-to-1 clamp;
  - the lowest-set-bit-to-index function shared with other arbiters.
- One sub-module, fixed_prio_arb (parameter NUM_PORTS): combinational lowest-index-wins one-hot encoder.
  - Instantiated twice, once for masked requests and once for raw requests.
  - Selection is "masked result if masked requests are non-zero, else raw result".

## Test plan
- Reset: drive reset mid-operation while ports 1 and 2 are requesting and port 1 is granted. Required: gnt_o=0, gnt_vld_o=0 and gnt_idx_o=0 asynchronously. After release, port 1 is granted first.
- Equal weights: req_i=4'b1111, all weights 1, ack_i=1 every cycle. Required: gnt_idx_o sequence 0,1,2,3,0,1 with no gaps.
- Weighted: weights {p0=3,p1=1,p2=2,p3=0}, all requesting, ack every cycle. Required grant order 0,0,0,1,2,2,3,0 (weight 0 behaves as 1).
- Withdrawal: port 2 is granted with weight 5. Drop req_i[2] after 1 ack while port 0 is requesting. Required: the next cycle grants port 0 (wrap-around); credit reloads from weight_i[0].
- Lone requester: only req_i[3]=1, weight 2, ack every cycle. Required: gnt_o=4'b1000 continuously, with gnt_vld_o never dropping.
- Stall: grant port 1 with weight 2 and hold ack_i=0 for 10 cycles. Required: the grant and credit are unchanged. Then 2 acks release the grant to the next requester.
